// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD write-bus receiver: command
// opcodes, receiver state encoding and the power-up address window.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC = 8'h3C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CASET = 3'd1,
        PASET = 3'd2,
        MEMWR = 3'd3,
        OTHER = 3'd4
    } lcd_state_e;

    // Default window after reset (240 x 320 panel).
    localparam int DEF_SC = 0;
    localparam int DEF_EC = 239;
    localparam int DEF_SP = 0;
    localparam int DEF_EP = 319;

    // State entered after a command byte.
    function automatic lcd_state_e cmd_next_state(input logic [7:0] cmd);
        lcd_state_e st;
        case (cmd)
            CMD_CASET:  st = CASET;
            CMD_PASET:  st = PASET;
            CMD_RAMWR:  st = MEMWR;
            CMD_RAMWRC: st = MEMWR;
            default:    st = OTHER;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus into i_clk and detects WR rising
// edges while chip select is active. Data and RS are taken from the same
// synchronizer stage as WR so the captured byte matches the edge.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_bus_data,
    input  logic       i_bus_rs,
    input  logic       i_bus_wr,
    input  logic       i_bus_cs_n,
    output logic [7:0] o_byte,
    output logic       o_rs,
    output logic       o_wr_edge,
    output logic       o_cs_release
);

    logic [SYNC_STAGES-1:0][7:0] data_q;
    logic [SYNC_STAGES-1:0]      rs_q;
    logic [SYNC_STAGES-1:0]      wr_q;
    logic [SYNC_STAGES-1:0]      cs_n_q;
    logic                        wr_prev_q;
    logic                        cs_n_prev_q;

    // Shift every bus line through its synchronizer chain. WR and CS_n reset
    // to their idle-high level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q      <= '0;
            rs_q        <= '0;
            wr_q        <= '1;
            cs_n_q      <= '1;
            wr_prev_q   <= 1'b1;
            cs_n_prev_q <= 1'b1;
        end else begin
            data_q      <= {data_q[SYNC_STAGES-2:0], i_bus_data};
            rs_q        <= {rs_q[SYNC_STAGES-2:0], i_bus_rs};
            wr_q        <= {wr_q[SYNC_STAGES-2:0], i_bus_wr};
            cs_n_q      <= {cs_n_q[SYNC_STAGES-2:0], i_bus_cs_n};
            wr_prev_q   <= wr_q[SYNC_STAGES-1];
            cs_n_prev_q <= cs_n_q[SYNC_STAGES-1];
        end
    end

    assign o_byte       = data_q[SYNC_STAGES-1];
    assign o_rs         = rs_q[SYNC_STAGES-1];
    assign o_wr_edge    = wr_q[SYNC_STAGES-1] & ~wr_prev_q & ~cs_n_q[SYNC_STAGES-1];
    assign o_cs_release = cs_n_q[SYNC_STAGES-1] & ~cs_n_prev_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder for the 8080-style LCD write bus. Decodes command / parameter
// bytes, tracks the CASET/PASET window and assembles memory-write byte pairs
// into RGB565 pixels tagged with their column/page coordinates.
//
// Output strobes (o_cmd_valid, o_param_valid, o_pixel_valid, o_frame_start)
// are single-cycle pulses with no back-pressure: the consumer must take the
// accompanying data in the cycle the strobe is high. The data outputs hold
// their value until the next strobe of the same kind. At most one of the
// three valid strobes is high in any cycle.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter bit LOW_BYTE_FIRST = 1'b1,
    parameter int COORD_W        = 9,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_bus_data,
    input  logic               i_bus_rs,
    input  logic               i_bus_wr,
    input  logic               i_bus_cs_n,
    output logic               o_cmd_valid,
    output logic [7:0]         o_cmd,
    output logic               o_param_valid,
    output logic [7:0]         o_param,
    output logic               o_pixel_valid,
    output logic [15:0]        o_pixel_data,
    output logic [COORD_W-1:0] o_pixel_x,
    output logic [COORD_W-1:0] o_pixel_y,
    output logic               o_frame_start,
    output logic               o_busy,
    output logic [2:0]         o_dbg_state
);

    logic [7:0] bus_byte;
    logic       bus_rs;
    logic       wr_edge;
    logic       cs_release;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_bus_data   (i_bus_data),
        .i_bus_rs     (i_bus_rs),
        .i_bus_wr     (i_bus_wr),
        .i_bus_cs_n   (i_bus_cs_n),
        .o_byte       (bus_byte),
        .o_rs         (bus_rs),
        .o_wr_edge    (wr_edge),
        .o_cs_release (cs_release)
    );

    lcd_state_e         state_q, state_d;
    logic               phase_q, phase_d;
    logic [2:0]         pidx_q, pidx_d;
    logic [23:0]        pbuf_q, pbuf_d;
    logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d;
    logic [COORD_W-1:0] sp_q, sp_d, ep_q, ep_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]         half_q, half_d;
    logic               arm_q, arm_d;

    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               param_valid_q, param_valid_d;
    logic [7:0]         param_q, param_d;
    logic               pix_valid_q, pix_valid_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               fs_q, fs_d;

    logic               row_end;
    logic [COORD_W-1:0] x_nxt, y_nxt;

    // Address the pixel after the current one inside the active window. An
    // inverted axis (end < start) pins that axis to its start value.
    always_comb begin
        row_end = (ec_q < sc_q) || (x_q == ec_q);
        x_nxt   = row_end ? sc_q : x_q + 1'b1;
        if (ep_q < sp_q) begin
            y_nxt = sp_q;
        end else if (row_end) begin
            y_nxt = (y_q == ep_q) ? sp_q : y_q + 1'b1;
        end else begin
            y_nxt = y_q;
        end
    end

    // Decode each synchronized write edge: commands, window parameters and pixels.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        pidx_d        = pidx_q;
        pbuf_d        = pbuf_q;
        sc_d          = sc_q;
        ec_d          = ec_q;
        sp_d          = sp_q;
        ep_d          = ep_q;
        x_d           = x_q;
        y_d           = y_q;
        half_d        = half_q;
        arm_d         = arm_q;
        cmd_valid_d   = 1'b0;
        cmd_d         = cmd_q;
        param_valid_d = 1'b0;
        param_d       = param_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        fs_d          = 1'b0;

        // Deselecting the panel abandons any half-received pixel.
        if (cs_release) begin
            phase_d = 1'b0;
        end

        if (wr_edge) begin
            if (!bus_rs) begin
                cmd_valid_d = 1'b1;
                cmd_d       = bus_byte;
                pidx_d      = 3'd0;
                phase_d     = 1'b0;
                state_d     = cmd_next_state(bus_byte);
                // Only a fresh memory write restarts the window and marks a frame.
                arm_d       = (bus_byte == CMD_RAMWR);
                if (bus_byte == CMD_RAMWR) begin
                    x_d = sc_q;
                    y_d = sp_q;
                end
            end else begin
                unique case (state_q)
                    CASET, PASET: begin
                        param_valid_d = 1'b1;
                        param_d       = bus_byte;
                        if (pidx_q != 3'd4) begin
                            pidx_d = pidx_q + 3'd1;
                        end
                        case (pidx_q)
                            3'd0: pbuf_d[23:16] = bus_byte;
                            3'd1: pbuf_d[15:8]  = bus_byte;
                            3'd2: pbuf_d[7:0]   = bus_byte;
                            3'd3: begin
                                // Both window registers change together on the last byte.
                                if (state_q == CASET) begin
                                    sc_d = COORD_W'({pbuf_q[23:16], pbuf_q[15:8]});
                                    ec_d = COORD_W'({pbuf_q[7:0], bus_byte});
                                end else begin
                                    sp_d = COORD_W'({pbuf_q[23:16], pbuf_q[15:8]});
                                    ep_d = COORD_W'({pbuf_q[7:0], bus_byte});
                                end
                            end
                            default: ;
                        endcase
                    end
                    MEMWR: begin
                        if (!phase_q) begin
                            half_d  = bus_byte;
                            phase_d = 1'b1;
                        end else begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = LOW_BYTE_FIRST ? {bus_byte, half_q}
                                                         : {half_q, bus_byte};
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            fs_d        = arm_q;
                            arm_d       = 1'b0;
                            x_d         = x_nxt;
                            y_d         = y_nxt;
                            phase_d     = 1'b0;
                        end
                    end
                    default: begin
                        param_valid_d = 1'b1;
                        param_d       = bus_byte;
                    end
                endcase
            end
        end
    end

    // Register decoder state, window and all outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            pidx_q        <= 3'd0;
            pbuf_q        <= '0;
            sc_q          <= COORD_W'(DEF_SC);
            ec_q          <= COORD_W'(DEF_EC);
            sp_q          <= COORD_W'(DEF_SP);
            ep_q          <= COORD_W'(DEF_EP);
            x_q           <= '0;
            y_q           <= '0;
            half_q        <= '0;
            arm_q         <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
            param_valid_q <= 1'b0;
            param_q       <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            fs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            pidx_q        <= pidx_d;
            pbuf_q        <= pbuf_d;
            sc_q          <= sc_d;
            ec_q          <= ec_d;
            sp_q          <= sp_d;
            ep_q          <= ep_d;
            x_q           <= x_d;
            y_q           <= y_d;
            half_q        <= half_d;
            arm_q         <= arm_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            param_valid_q <= param_valid_d;
            param_q       <= param_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            fs_q          <= fs_d;
        end
    end

    assign o_cmd_valid   = cmd_valid_q;
    assign o_cmd         = cmd_q;
    assign o_param_valid = param_valid_q;
    assign o_param       = param_q;
    assign o_pixel_valid = pix_valid_q;
    assign o_pixel_data  = pix_data_q;
    assign o_pixel_x     = pix_x_q;
    assign o_pixel_y     = pix_y_q;
    assign o_frame_start = fs_q;
    assign o_busy        = (state_q == MEMWR);
    assign o_dbg_state   = state_q;

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Responder side of the 8080-style 8-bit parallel LCD write bus (DATA[7:0], RS, WR, CS_n). Typical use: the FPGA sits between the host MCU and the panel, and this block decodes the host's writes.
- Oversamples the bus in i_clk and detects WR rising edges. Emits raw command/parameter strobes.
- Tracks the Column Address Set (0x2A) and Page Address Set (0x2B) windows and assembles Memory Write (0x2C) / Memory Write Continue (0x3C) byte pairs into RGB565 pixels tagged with x/y coordinates.

Parameters:
- LOW_BYTE_FIRST, 1, 1: first pixel byte is [7:0] and second is [15:8] (matches our transmitter). 0: high byte first.
- COORD_W, 9, coordinate width. Column and page parameters are truncated to COORD_W bits.
- SYNC_STAGES, 2, synchronizer depth for every bus input (minimum 2).

Ports:
- i_clk, in, 1, system clock; must be at least 4x the bus WR rate.
- i_reset, in, 1, asynchronous, active-high reset.
- i_bus_data, in, 8, bus data; stable around the WR rising edge.
- i_bus_rs, in, 1, 0 = command byte, 1 = data/parameter byte.
- i_bus_wr, in, 1, write strobe; the byte is taken on its rising edge.
- i_bus_cs_n, in, 1, chip select, active low.
- o_cmd_valid, out, 1, one-cycle strobe: a command byte was received.
- o_cmd, out, 8, last command byte.
- o_param_valid, out, 1, one-cycle strobe: a data byte was received outside memory write.
- o_param, out, 8, that data byte.
- o_pixel_valid, out, 1, one-cycle strobe: a pixel was completed.
- o_pixel_data, out, 16, RGB565 pixel.
- o_pixel_x, out, COORD_W, column of the pixel.
- o_pixel_y, out, COORD_W, page of the pixel.
- o_frame_start, out, 1, one-cycle strobe coincident with the first pixel after a 0x2C.
- o_busy, out, 1, high while in MEMWR.

Behaviour:
- Reset: all outputs 0. Window registers SC=0, EC=239, SP=0, EP=319. State IDLE, byte phase 0, param index 0.
- Input capture:
  - data, rs, wr and cs_n each pass through SYNC_STAGES flops.
  - Edge = synchronized wr is 1 while its previous value was 0, with synchronized cs_n = 0.
  - Data and rs are taken from the same synchronizer stage as wr.
  - Strobes assert exactly SYNC_STAGES+1 i_clk cycles after the raw WR rising edge.
- Any edge with rs=0 (a command):
  - o_cmd_valid=1 and o_cmd=byte.
  - Param index and byte phase clear.
  - Next state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> MEMWR (x=SC, y=SP, arm frame_start), 0x3C -> MEMWR (x/y kept), anything else -> OTHER.
- CASET / PASET, edge with rs=1:
  - o_param_valid pulses.
  - Params 0..3 map to start[15:8], start[7:0], end[15:8], end[7:0].
  - Registers update on the 4th byte only, atomically. A new command before the 4th byte discards the partial set.
  - Bytes beyond the 4th raise o_param_valid only.
- OTHER, edge with rs=1: o_param_valid pulses; no other effect.
- MEMWR, edge with rs=1:
  - No o_param_valid.
  - Phase 0: latch the byte into half A, phase becomes 1.
  - Phase 1: build the pixel per LOW_BYTE_FIRST, then pulse o_pixel_valid with the current x/y, and phase becomes 0.
- Address advance after each pixel:
  - If x == EC: x = SC, and y = (y == EP) ? SP : y+1.
  - Otherwise x = x+1.
  - If EC < SC (or EP < SP), that axis holds at its start value.
- Pixel outputs:
  - o_pixel_data, o_pixel_x and o_pixel_y hold until the next pixel.
  - o_frame_start pulses with the first pixel after a 0x2C only, not after 0x3C.
- cs_n deasserting (synchronized 0->1):
  - Byte phase clears and a half pixel is dropped.
  - State and window are retained.
- Async reset mid-transfer aborts immediately with no partial outputs.
- At most one strobe per edge. Strobes never overlap: o_cmd_valid, o_param_valid and o_pixel_valid are mutually exclusive.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, CMD_RAMWRC=8'h3C;
  - the state enum IDLE/CASET/PASET/MEMWR/OTHER;
  - default window constants.
- Sub-module lcd_bus_sync handles synchronizers plus edge detect; it outputs byte, rs and a one-cycle edge strobe.

Test Plan:
- 0x2A, 00, 10, 00, 12, then 0x2B, 00, 05, 00, 06, then 0x2C and 12 data bytes:
  - 6 pixels at (16,5), (17,5), (18,5), (16,6), (17,6), (18,6), then wrap to (16,5);
  - o_frame_start only on the first pixel.
- LOW_BYTE_FIRST=1, bytes 0x1F then 0xF8 -> o_pixel_data=16'hF81F. LOW_BYTE_FIRST=0, same bytes -> 16'h1FF8.
- 0x2C, 3 bytes (1.5 pixels), then 0x3C, bytes 0x00, 0xFF:
  - half pixel dropped;
  - the second pixel carries the next coordinate (no frame_start) with the new data.
- 0x2A with only 2 params, then 0x2C: window unchanged (SC=0, EC=239); first pixel at (0,0).
- Command 0x11, then data 0x55:
  - o_cmd_valid with o_cmd=8'h11;
  - o_param_valid with o_param=8'h55;
  - no pixel.
- Writes with cs_n=1 are ignored. i_reset asserted mid-pixel: all outputs 0 immediately, and after release the window is back to defaults.
